// File: rtl/pattern_pkg.sv
// Shared types and helpers for the pattern sequencer and pattern generators.
// Colour is 6-bit RGB, three 2-bit channels; fade levels dim each channel independently.
package pattern_pkg;

    localparam int RGB_W = 6;
    localparam int CH_W  = 2;

    typedef enum logic [1:0] {
        FADE_NONE  = 2'd0,
        FADE_HALF  = 2'd1,
        FADE_BLACK = 2'd2
    } fade_level_e;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FADE_OUT1 = 2'd1,
        FADE_OUT2 = 2'd2,
        FADE_IN   = 2'd3
    } fade_state_e;

    function automatic logic [RGB_W-1:0] dim_rgb(input logic [RGB_W-1:0] rgb,
                                                 input fade_level_e level);
        logic [RGB_W-1:0] res;
        res = '0;
        for (int c = 0; c < RGB_W / CH_W; c++) begin
            case (level)
                FADE_NONE: res[c*CH_W +: CH_W] = rgb[c*CH_W +: CH_W];
                FADE_HALF: res[c*CH_W +: CH_W] = rgb[c*CH_W +: CH_W] >> 1;
                default:   res[c*CH_W +: CH_W] = '0;
            endcase
        end
        return res;
    endfunction

endpackage

// File: rtl/frame_tick_det.sv
// Frame origin detector: one-cycle frame_tick on the rising edge of active-low vsync.
// vsync_q resets high so a high vsync at reset release does not produce a tick.
module frame_tick_det (
    input  logic clk,
    input  logic rst_n,
    input  logic vsync,
    output logic frame_tick
);

    logic vsync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) vsync_q <= 1'b1;
        else        vsync_q <= vsync;
    end

    assign frame_tick = vsync & ~vsync_q;

endmodule

// File: rtl/pattern_sequencer.sv
// Selects one of NUM_PATTERNS generators, with auto-cycling and manual stepping applied at frame origin.
// Build option PATTERN_FADE_EN: switches go through a fade-out / fade-in sequence over four frame ticks.
//
// fade state | meaning
// IDLE       | no transition in progress, requests are evaluated at frame_tick
// FADE_OUT1  | old pattern at half brightness
// FADE_OUT2  | black; sel switches at the next frame_tick
// FADE_IN    | new pattern at half brightness
module pattern_sequencer
    import pattern_pkg::*;
#(
    parameter int NUM_PATTERNS = 3,
    parameter int DWELL_W      = 10,
    parameter int SEL_W        = $clog2(NUM_PATTERNS)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          vsync,
    input  logic                          paused,
    input  logic                          auto_en,
    input  logic [DWELL_W-1:0]            dwell,
    input  logic                          btn_next,
    input  logic                          btn_prev,
    input  logic [RGB_W*NUM_PATTERNS-1:0] rgb_in,
    output logic [SEL_W-1:0]              sel,
    output logic [NUM_PATTERNS-1:0]       next_frame,
    output logic [NUM_PATTERNS-1:0]       pattern_rst,
    output logic                          wrap,
    output logic [RGB_W-1:0]              rgb
);

    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_PATTERNS - 1);

    logic                    frame_tick;
    logic [SEL_W-1:0]        sel_q;
    logic                    pend_next;
    logic                    pend_prev;
    logic [DWELL_W-1:0]      frame_cnt;
    logic [DWELL_W-1:0]      dwell_m1;
    logic                    pend_both;
    logic                    manual_req;
    logic                    auto_req;
    logic                    decide;
    logic                    decide_fwd;
    logic                    idle;
    logic                    apply;
    logic                    apply_fwd;
    logic [SEL_W-1:0]        sel_fwd;
    logic [SEL_W-1:0]        sel_bwd;
    logic [SEL_W-1:0]        sel_target;
    logic [NUM_PATTERNS-1:0] prst_nxt;
    logic [NUM_PATTERNS-1:0] prst_q;
    logic                    wrap_q;
    logic [RGB_W-1:0]        rgb_raw;

    frame_tick_det u_tick (
        .clk        (clk),
        .rst_n      (rst_n),
        .vsync      (vsync),
        .frame_tick (frame_tick)
    );

    // Switch decision at frame origin; opposing manual requests cancel and also suppress auto advance.
    always_comb begin
        dwell_m1   = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
        pend_both  = pend_next & pend_prev;
        manual_req = pend_next ^ pend_prev;
        auto_req   = auto_en & ~paused & (frame_cnt >= dwell_m1);
        decide     = ~pend_both & (manual_req | auto_req);
        decide_fwd = manual_req ? pend_next : 1'b1;
    end

    always_comb begin
        sel_fwd    = (sel_q == LAST_SEL) ? '0 : sel_q + SEL_W'(1);
        sel_bwd    = (sel_q == '0) ? LAST_SEL : sel_q - SEL_W'(1);
        sel_target = apply_fwd ? sel_fwd : sel_bwd;
        prst_nxt   = '0;
        for (int k = 0; k < NUM_PATTERNS; k++) begin
            prst_nxt[k] = (sel_target == SEL_W'(k));
        end
    end

`ifdef PATTERN_FADE_EN
    fade_state_e state_q, state_d;
    logic        dir_q, dir_d;
    fade_level_e level;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dir_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        level   = FADE_NONE;
        apply   = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_tick && decide) begin
                    state_d = FADE_OUT1;
                    dir_d   = decide_fwd;
                end
            end
            FADE_OUT1: begin
                level = FADE_HALF;
                if (frame_tick) state_d = FADE_OUT2;
            end
            FADE_OUT2: begin
                level = FADE_BLACK;
                if (frame_tick) begin
                    state_d = FADE_IN;
                    apply   = 1'b1;
                end
            end
            FADE_IN: begin
                level = FADE_HALF;
                if (frame_tick) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign idle      = (state_q == IDLE);
    assign apply_fwd = dir_q;
    assign rgb       = dim_rgb(rgb_raw, level);
`else
    assign idle      = 1'b1;
    assign apply     = frame_tick & decide;
    assign apply_fwd = decide_fwd;
    assign rgb       = rgb_raw;
`endif

    // Requests raised during a fade stay latched; a button in the tick cycle carries to the next tick.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_q     <= '0;
            pend_next <= 1'b0;
            pend_prev <= 1'b0;
            frame_cnt <= '0;
            prst_q    <= '0;
            wrap_q    <= 1'b0;
        end else begin
            prst_q <= '0;
            wrap_q <= 1'b0;
            if (apply) begin
                sel_q  <= sel_target;
                prst_q <= prst_nxt;
                wrap_q <= apply_fwd & (sel_q == LAST_SEL);
            end
            if (frame_tick && idle) begin
                pend_next <= btn_next;
                pend_prev <= btn_prev;
                if (decide)
                    frame_cnt <= '0;
                else if (!paused && frame_cnt != '1)
                    frame_cnt <= frame_cnt + DWELL_W'(1);
            end else begin
                pend_next <= pend_next | btn_next;
                pend_prev <= pend_prev | btn_prev;
            end
        end
    end

    always_comb begin
        next_frame = '0;
        rgb_raw    = '0;
        for (int k = 0; k < NUM_PATTERNS; k++) begin
            next_frame[k] = frame_tick & ~paused & (sel_q == SEL_W'(k));
            if (sel_q == SEL_W'(k)) rgb_raw = rgb_in[RGB_W*k +: RGB_W];
        end
    end

    assign sel         = sel_q;
    assign pattern_rst = prst_q;
    assign wrap        = wrap_q;

endmodule

// File: doc/pattern_sequencer.md
Name: pattern_sequencer

Overview:
Parametrised successor to the fixed three-pattern selector. Selects one of NUM_PATTERNS pattern generators and muxes its 6-bit RGB onto the VGA output. Supports auto-cycling with a runtime-programmable dwell (in frames) and manual next/prev stepping. All switches are deferred to the next frame origin (vsync rising edge). Sits between the pattern generators and the VGA output stage; drives each generator's next_frame and reset strobes.

Parameters:
NUM_PATTERNS, 3, number of pattern generators (2..16)
DWELL_W, 10, width of dwell input (frames per pattern)
SEL_W, $clog2(NUM_PATTERNS), width of the pattern index

Ports:
clk  in  1  pixel clock
rst_n  in  1  synchronous active-low reset
vsync  in  1  VGA vsync, active low
paused  in  1  freeze animation and auto-advance
auto_en  in  1  1 = auto-cycle, 0 = manual-only
dwell  in  DWELL_W  frames per pattern in auto mode
btn_next  in  1  one-cycle pulse: step forward
btn_prev  in  1  one-cycle pulse: step backward
rgb_in  in  6*NUM_PATTERNS  packed generator outputs; pattern k at [6k+5:6k]
sel  out  SEL_W  current pattern index
next_frame  out  NUM_PATTERNS  one-hot animation strobe
pattern_rst  out  NUM_PATTERNS  one-hot one-cycle reset strobe for the newly selected pattern
wrap  out  1  one-cycle pulse on forward wrap NUM_PATTERNS-1 -> 0
rgb  out  6  selected pattern colour

Behaviour:
- Reset is sampled on clk only, while rst_n=0. Reset values:
  - sel=0, frame_cnt=0, vsync_q=1.
  - Pending requests cleared; next_frame=0, pattern_rst=0, wrap=0.
- frame_tick = vsync & ~vsync_q (rising edge, end of the vsync pulse). vsync_q is updated every cycle.
- next_frame[k] = frame_tick & ~paused & (sel==k). It is combinational, so it asserts in the same cycle as frame_tick.
- Manual requests:
  - btn_next sets pend_next; btn_prev sets pend_prev. Both are latched until the next frame_tick.
  - Requests are honoured even when paused or when auto_en=0.
  - If both pend_next and pend_prev are set at the frame_tick, they cancel: no switch, both cleared.
  - A button pulse in the same cycle as frame_tick is latched for the following tick.
- Auto advance: at frame_tick, when auto_en & ~paused & (frame_cnt >= eff_dwell-1), advance forward.
  - eff_dwell = (dwell==0) ? 1 : dwell.
  - The >= comparison lets a lowered dwell take effect on the next tick.
- Priority at frame_tick: manual request over auto advance. Any switch clears frame_cnt to 0.
- With no switch: frame_cnt increments at frame_tick only when ~paused; it saturates at all-ones.
- Forward step: sel = (sel==NUM_PATTERNS-1) ? 0 : sel+1. wrap=1 for one cycle when the step goes from NUM_PATTERNS-1 to 0.
- Backward step: sel = (sel==0) ? NUM_PATTERNS-1 : sel-1. Never asserts wrap.
- Switch timing: sel updates the cycle after frame_tick. pattern_rst[new sel] is asserted for exactly that one cycle, registered.
- rgb is a combinational mux of rgb_in[6*sel +: 6]. Any out-of-range sel outputs 0.
- rst_n asserted mid-fade or mid-request discards all pending state.

Optional Feature:
Macro: PATTERN_FADE_EN.
Defined:
- A switch decision enters a fade sequence instead of switching directly.
- Sequence: FADE_OUT1 (level 1), then FADE_OUT2 (level 2, black). At the next frame_tick, sel switches and pattern_rst fires, entering FADE_IN (level 1). At the next frame_tick, back to IDLE (level 0).
- Each state advances on frame_tick. The switch therefore takes effect 2 ticks later and the full transition spans 4 ticks.
- Level is applied per 2-bit channel: level 0 = unchanged, level 1 = channel>>1, level 2 = 0.
- Requests arriving during a fade stay pending until IDLE. frame_cnt holds during the fade.
- paused does not stall the fade.
Undefined: switches are immediate as described above and rgb is never dimmed.

Decomposition:
- Shared package pattern_pkg:
  - RGB_W=6, CH_W=2
  - fade level encoding (FADE_NONE/HALF/BLACK)
  - fade state enum (IDLE, FADE_OUT1, FADE_OUT2, FADE_IN)
  - a dim_rgb(rgb, level) function
- One sub-module, frame_tick_det: vsync edge register and frame_tick output. It is reusable by the generators.

Test Plan:
- Reset, NUM_PATTERNS=3, auto_en=1, dwell=4, no pauses, 12 vsync pulses -> sel sequence 0,1,2,0. wrap asserts exactly once, one cycle after the 12th rising edge. pattern_rst one-hot 010, 100, 001 at the switches.
- sel=0, btn_prev pulse mid-frame -> no change until the next frame_tick; then sel=2, wrap=0, pattern_rst=100, frame_cnt=0.
- btn_next and btn_prev in the same frame -> sel unchanged at the tick; both pending flags cleared.
- paused=1 with auto_en=1 for 10 frames -> next_frame stays 0 and sel is constant. Then btn_next -> sel increments at the next tick even though paused.
- dwell=0 -> sel advances on every frame_tick. Set dwell=8 while frame_cnt=5, then lower dwell to 3 -> switch at the next tick.
- With PATTERN_FADE_EN, rgb_in pattern 0 = 6'b111111, auto switch -> rgb per tick: 010101, 000000, then pattern-1 value>>1, then full. sel changes at the third tick.
